// File: rtl/prescaler_pkg.sv
// prescaler_bank shared types, defaults and helpers.
// Channel state is sized for the widest legal prescale.
package prescaler_pkg;

  localparam int NCH_DEF   = 4;
  localparam int PRE_W_DEF = 6;
  localparam int NCH_MAX   = 16;
  localparam int PRE_MAX   = 16;
  localparam int VEC_MAX   = NCH_MAX * PRE_MAX;

  typedef struct packed {
    logic [PRE_MAX-1:0] cnt;
    logic [PRE_MAX-1:0] shd;
    logic               out;
  } chan_st_t;

  function automatic logic [PRE_MAX-1:0] pre_slice(
    input logic [VEC_MAX-1:0] vec,
    input int                 i,
    input int                 w
  );
    logic [VEC_MAX-1:0] mask;
    mask = (VEC_MAX'(1) << w) - VEC_MAX'(1);
    return PRE_MAX'((vec >> (i * w)) & mask);
  endfunction

endpackage

// File: rtl/prescaler_chan.sv
// One prescaler channel: counter, shadow prescale, 50% output.
// Tick register exists only with PRESCALER_BANK_TICK_EN defined.
module prescaler_chan
  import prescaler_pkg::*;
#(
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [PRE_W-1:0] pre,
  output logic             clk_out,
  output logic             tick
);

  chan_st_t           st;
  logic [PRE_MAX-1:0] pre_x;
  logic               restart;
  logic               term;

  assign pre_x   = PRE_MAX'(pre);
  assign restart = rst | ~en | sync;
  assign term    = (st.cnt == st.shd);
  assign clk_out = st.out;

  // Restart, toggle at terminal count (reloading shadow), else count
  always_ff @(posedge clk) begin
    if (restart) begin
      st.cnt <= '0;
      st.out <= 1'b0;
      st.shd <= pre_x;
    end else if (term) begin
      st.cnt <= '0;
      st.out <= ~st.out;
      st.shd <= pre_x;
    end else begin
      st.cnt <= st.cnt + PRE_MAX'(1);
    end
  end

`ifdef PRESCALER_BANK_TICK_EN
  // Strobe on the same edge the output goes low to high
  always_ff @(posedge clk) begin
    if (restart) begin
      tick <= 1'b0;
    end else begin
      tick <= term & ~st.out;
    end
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/prescaler_bank.sv
// NCH-channel 50%-duty clock-enable prescaler with common sync.
// Optional tick strobes: define PRESCALER_BANK_TICK_EN.
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     en,
  input  logic [NCH*PRE_W-1:0] pre,
  input  logic               sync,
  output logic [NCH-1:0]     clk_out,
  output logic [NCH-1:0]     tick
);

  logic [VEC_MAX-1:0] pre_x;

  assign pre_x = VEC_MAX'(pre);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [PRE_W-1:0] pre_i;

    assign pre_i = PRE_W'(pre_slice(pre_x, i, PRE_W));

    prescaler_chan #(
      .PRE_W (PRE_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .pre     (pre_i),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// Self-checking bench for prescaler_bank (NCH=4, PRE_W=6).
// Reference model tracks absolute toggle times per channel.
module tb_prescaler_bank;

  localparam int NCH   = 4;
  localparam int PRE_W = 6;
`ifdef PRESCALER_BANK_TICK_EN
  localparam bit TICK = 1'b1;
`else
  localparam bit TICK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sync;
  logic [NCH-1:0]       en;
  logic [NCH*PRE_W-1:0] pre;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;

  int checks = 0;
  int errors = 0;
  int n = 0;

  bit     lvl [NCH];
  bit     tk  [NCH];
  longint nxt [NCH];

  prescaler_bank #(
    .NCH   (NCH),
    .PRE_W (PRE_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pre     (pre),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH*PRE_W-1:0] pre;
    logic                 sync;
    int                   cyc;
  } seg_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, n, act, exp);
    end
  endtask

  // Next toggle happens P+1 edges after a restart or previous toggle.
  task automatic model_edge();
    int p;
    for (int i = 0; i < NCH; i++) begin
      p = int'(pre[i*PRE_W +: PRE_W]);
      if (rst || !en[i] || sync) begin
        lvl[i] = 1'b0;
        tk[i]  = 1'b0;
        nxt[i] = n + p + 1;
      end else if (n == nxt[i]) begin
        lvl[i] = !lvl[i];
        tk[i]  = lvl[i];
        nxt[i] = n + p + 1;
      end else begin
        tk[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] eo;
    logic [NCH-1:0] et;
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      eo[i] = lvl[i];
      et[i] = TICK ? tk[i] : 1'b0;
    end
    check("clk_out", 32'(clk_out), 32'(eo));
    check("tick", 32'(tick), 32'(et));
  endtask

  task automatic set_pre(input int ch, input int v);
    pre[ch*PRE_W +: PRE_W] = PRE_W'(v);
  endtask

  seg_t tbl [9];
  int   base;
  int   tq [$];
  logic prev;

  initial begin
    rst  = 1'b1;
    sync = 1'b0;
    en   = '0;
    pre  = '0;

    tbl[0] = '{1'b1, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd10}, 1'b0, 3};
    tbl[1] = '{1'b0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd10}, 1'b0, 70};
    tbl[2] = '{1'b0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd0}, 1'b0, 12};
    tbl[3] = '{1'b0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd63}, 1'b0, 300};
    tbl[4] = '{1'b0, 4'b1111, {6'd9, 6'd5, 6'd5, 6'd2}, 1'b1, 40};
    tbl[5] = '{1'b0, 4'b1101, {6'd9, 6'd5, 6'd5, 6'd2}, 1'b0, 6};
    tbl[6] = '{1'b0, 4'b1111, {6'd9, 6'd5, 6'd5, 6'd2}, 1'b0, 20};
    tbl[7] = '{1'b1, 4'b1111, {6'd9, 6'd5, 6'd5, 6'd2}, 1'b0, 1};
    tbl[8] = '{1'b0, 4'b1111, {6'd9, 6'd5, 6'd5, 6'd2}, 1'b0, 20};

    for (int s = 0; s < 9; s++) begin
      rst  = tbl[s].rst;
      en   = tbl[s].en;
      pre  = tbl[s].pre;
      sync = tbl[s].sync;
      for (int c = 0; c < tbl[s].cyc; c++) begin
        step();
        sync = 1'b0;
        if (s == 4)
          check("ch1_eq_ch2", 32'(clk_out[1]), 32'(clk_out[2]));
      end
    end

    // pre change mid half-period: old half completes, then new length
    en   = 4'b0001;
    pre  = '0;
    set_pre(0, 10);
    sync = 1'b1;
    step();
    sync = 1'b0;
    base = n;
    prev = clk_out[0];
    for (int k = 0; k < 40; k++) begin
      step();
      if (clk_out[0] !== prev) tq.push_back(n - base);
      prev = clk_out[0];
      if (n == base + 15) set_pre(0, 3);
    end
    if (tq.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL pre_change_toggles: got %0d toggles expected 4+",
               tq.size());
    end else begin
      check("first_rise", 32'(tq[0]), 32'd11);
      check("old_half", 32'(tq[1] - tq[0]), 32'd11);
      check("new_half_a", 32'(tq[2] - tq[1]), 32'd4);
      check("new_half_b", 32'(tq[3] - tq[2]), 32'd4);
    end

    // sync landing on a terminal count suppresses the toggle
    set_pre(0, 2);
    sync = 1'b1;
    step();
    base = n;
    sync = 1'b0;
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_term_out", 32'(clk_out[0]), 32'd0);
    check("sync_term_tick", 32'(tick[0]), 32'd0);
    step();
    step();
    step();
    check("rise_after_sync", 32'(clk_out[0]), 32'd1);
    check("rise_tick", 32'(tick[0]), 32'(TICK));

    // randomized run against the model
    en = 4'b1111;
    for (int k = 0; k < 1500; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      sync = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 29) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 9) == 0)
          set_pre(i, ($urandom_range(0, 7) == 0) ? 63
                                               : $urandom_range(0, 12));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
